// File: rtl/frame_buffer_sequencer.sv
// rtl/frame_buffer_sequencer.sv - captures one frame into RAM, then streams it out in raster order
// Optional build macro FBS_HDECIMATE_EN: store only even-x pixels (2:1 horizontal subsampling).
module frame_buffer_sequencer #(
  parameter int H_ACTIVE = 64,
  parameter int V_ACTIVE = 48,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [11:0]       x,
  input  logic [11:0]       y,
  input  logic [DATA_W-1:0] pix_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

`ifdef FBS_HDECIMATE_EN
  localparam int         ROW_PIX = H_ACTIVE / 2;
  localparam logic [11:0] LAST_X = 12'(H_ACTIVE - 2);
`else
  localparam int         ROW_PIX = H_ACTIVE;
  localparam logic [11:0] LAST_X = 12'(H_ACTIVE - 1);
`endif
  localparam int                N_PIX      = ROW_PIX * V_ACTIVE;
  localparam logic [11:0]       H_LIM      = 12'(H_ACTIVE);
  localparam logic [11:0]       V_LIM      = 12'(V_ACTIVE);
  localparam logic [11:0]       LAST_Y     = 12'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] RD_LAST    = ADDR_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(ROW_PIX);

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  logic              keep_pix;
  logic              wr_fire;
  logic              wr_last;
  logic [ADDR_W-1:0] wr_addr;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_inflight;
  logic              rd_issue;
  logic              rd_last;

  // Two-entry output FIFO; occupancy plus the read in flight never exceeds two.
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wptr;
  logic              fifo_rptr;
  logic [1:0]        fifo_count;
  logic [1:0]        fifo_count_nxt;
  logic [1:0]        fifo_level;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drain_done;
  logic              drop_evt;

  // Write-side decode: window test, RAM address and the frame-closing pixel.
  always_comb begin
`ifdef FBS_HDECIMATE_EN
    keep_pix = (x < H_LIM) && (y < V_LIM) && !x[0];
    wr_addr  = ADDR_W'(y) * ROW_STRIDE + ADDR_W'(x >> 1);
`else
    keep_pix = (x < H_LIM) && (y < V_LIM);
    wr_addr  = ADDR_W'(y) * ROW_STRIDE + ADDR_W'(x);
`endif
    wr_fire  = (state == S_WRITE) && pix_valid && keep_pix;
    wr_last  = wr_fire && (x == LAST_X) && (y == LAST_Y);
    drop_evt = pix_valid && (state != S_WRITE);
  end

  // Read-side flow control: issue a RAM read only when the FIFO is sure to have room.
  always_comb begin
    fifo_pop       = (fifo_count != 2'd0) && out_ready;
    fifo_push      = rd_inflight;
    fifo_level     = fifo_count + {1'b0, rd_inflight};
    rd_issue       = (state == S_READ) &&
                     ((fifo_level < 2'd2) || ((fifo_level == 2'd2) && fifo_pop));
    rd_last        = rd_issue && (rd_addr == RD_LAST);
    fifo_count_nxt = fifo_count + {1'b0, fifo_push} - {1'b0, fifo_pop};
    drain_done     = (state == S_DRAIN) && !rd_inflight && (fifo_count_nxt == 2'd0);
  end

  // Next-state logic; frame_start outside IDLE has no effect.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_start) state_nxt = S_WRITE;
      S_WRITE: if (wr_last)     state_nxt = S_READ;
      S_READ:  if (rd_last)     state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus busy and frame_done, which track the state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt == S_READ) || (state_nxt == S_DRAIN);
      frame_done <= drain_done;
    end
  end

  // Read address walks once per frame and parks on the last address until IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      if (state == S_IDLE) begin
        rd_addr <= '0;
      end else if (rd_issue && !rd_last) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

  // Output FIFO: RAM data lands one cycle after its read was issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wptr   <= 1'b0;
      fifo_rptr   <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_wptr] <= mem_rdata;
        fifo_wptr           <= ~fifo_wptr;
      end
      if (fifo_pop) begin
        fifo_rptr <= ~fifo_rptr;
      end
      fifo_count <= fifo_count_nxt;
    end
  end

  // Saturating count of pixels that arrive while no capture is open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 16'd0;
    end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign mem_we    = wr_fire;
  assign mem_waddr = wr_fire ? wr_addr : '0;
  assign mem_wdata = wr_fire ? pix_data : '0;
  assign mem_re    = rd_issue;
  assign mem_raddr = rd_addr;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = out_valid ? fifo_mem[fifo_rptr] : '0;

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// tb/tb_frame_buffer_sequencer.sv - scoreboard bench for frame_buffer_sequencer (4x2 frame)
module tb_frame_buffer_sequencer;

`ifdef FBS_HDECIMATE_EN
  localparam int NPIX = 4;
  localparam bit DEC  = 1'b1;
`else
  localparam int NPIX = 8;
  localparam bit DEC  = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic [11:0] px;
  logic [11:0] py;
  logic [7:0]  pix_data;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [11:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_done;
  logic [15:0] drop_cnt;

  frame_buffer_sequencer #(.H_ACTIVE(4), .V_ACTIVE(2), .DATA_W(8), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(px), .y(py), .pix_data(pix_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        wexp_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] img [0:15];
  logic [7:0] ram [0:4095];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  acc_cnt = 0;
  int  first_acc_cyc = 0;
  int  last_acc_cyc = 0;
  int  done_cnt = 0;
  int  outstanding = 0;
  bit  ready_mode = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? !out_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares writes and accepted output against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (mem_we) begin
        if (wexp_q.size() == 0) begin
          check("unexpected_write_addr", {20'd0, mem_waddr}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = wexp_q.pop_front();
          check("write_addr", {20'd0, mem_waddr}, {20'd0, w.addr});
          check("write_data", {24'd0, mem_wdata}, {24'd0, w.data});
        end
      end
      if (mem_we && mem_re) check("we_re_exclusive", 32'd1, 32'd0);
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_data_stable", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("stream_data", {24'd0, out_data}, {24'd0, e});
        end
        if (acc_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
        outstanding--;
      end
      if (mem_re) begin
        outstanding++;
        check("read_overrun", (outstanding <= 2) ? 32'd1 : 32'd0, 32'd1);
      end
      if (frame_done) begin
        done_cnt++;
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("stream_complete_at_done", exp_q.size(), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Drives one pixel for one cycle; when tracked, records the expected RAM write.
  task automatic send_pix(input int xx, input int yy, input logic [7:0] d, input bit track);
    int a;
    bit keep;
    @(posedge clk);
    #1;
    pix_valid = 1'b1;
    px        = 12'(xx);
    py        = 12'(yy);
    pix_data  = d;
    keep = (xx < 4) && (yy < 2) && (!DEC || (xx % 2 == 0));
    a    = DEC ? (yy * 2 + xx / 2) : (yy * 4 + xx);
    if (track && keep) begin
      wexp_q.push_back({12'(a), d});
      img[a] = d;
    end
  endtask

  task automatic idle_pix();
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  // order 0: raster; order 1: row 1 (minus its closing pixel), row 0, then the closing pixel.
  task automatic send_frame(input int order, input bit inject_oob, input int extra_drops);
    int lx;
    lx = DEC ? 2 : 3;
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    if (order == 0) begin
      for (int yy = 0; yy < 2; yy++) begin
        for (int xx = 0; xx < 4; xx++) begin
          send_pix(xx, yy, 8'(8'h10 + yy * 4 + xx), 1'b1);
          if (inject_oob && xx == 0 && yy == 0) send_pix(5, 0, 8'hEE, 1'b1);
        end
      end
    end else begin
      for (int xx = 0; xx < 4; xx++)
        if (xx != lx) send_pix(xx, 1, 8'(8'h14 + xx), 1'b1);
      for (int xx = 0; xx < 4; xx++) send_pix(xx, 0, 8'(8'h10 + xx), 1'b1);
      check("no_read_before_last", {31'd0, busy}, 32'd0);
      send_pix(lx, 1, 8'(8'h14 + lx), 1'b1);
    end
    for (int a = 0; a < NPIX; a++) exp_q.push_back(img[a]);
    for (int i = 0; i < extra_drops; i++) send_pix(1, 1, 8'hAA, 1'b0);
    idle_pix();
  endtask

  task automatic wait_done(input int prev);
    int i;
    i = 0;
    while (done_cnt == prev && i < 300) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("frame_done_seen", done_cnt, prev + 1);
    repeat (4) @(negedge clk);
    #1;
    check("frame_done_once", done_cnt, prev + 1);
    check("busy_low_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_mem_we_re"}, {30'd0, mem_we, mem_re}, 32'd0);
    check({tag, "_mem_raddr"}, {20'd0, mem_raddr}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    int d0;
    int i;
    rst         = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    px          = 12'd0;
    py          = 12'd0;
    pix_data    = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Test 1: raster frame, consumer always ready.
    d0 = done_cnt;
    send_frame(0, 1'b0, 0);
    wait_done(d0);
    check("t1_stream_count", acc_cnt, NPIX);
    check("t1_back_to_back", last_acc_cyc - first_acc_cyc, NPIX - 1);
    check("t1_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Test 2: same frame with a toggling consumer.
    ready_mode = 1'b1;
    d0 = done_cnt;
    send_frame(0, 1'b0, 0);
    wait_done(d0);
    check("t2_stream_count", acc_cnt, NPIX);
    ready_mode = 1'b0;

    // Test 3: drops in IDLE and READ; out-of-window pixel in WRITE neither writes nor counts.
    for (int k = 0; k < 3; k++) send_pix(k, 0, 8'h55, 1'b0);
    idle_pix();
    check("t3_idle_drops", {16'd0, drop_cnt}, 32'd3);
    d0 = done_cnt;
    send_frame(0, 1'b1, 2);
    wait_done(d0);
    check("t3_drop_cnt", {16'd0, drop_cnt}, 32'd5);

    // Test 4: out-of-order capture still streams by address.
    d0 = done_cnt;
    send_frame(1, 1'b0, 0);
    wait_done(d0);
    check("t4_stream_count", acc_cnt, NPIX);

    // Test 5: reset in the middle of streaming, then a clean frame.
    d0 = done_cnt;
    send_frame(0, 1'b0, 0);
    i = 0;
    while (acc_cnt < 3 && i < 200) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("t5_three_out", acc_cnt, 3);
    rst = 1'b0;
    #1;
    exp_q.delete();
    wexp_q.delete();
    check_reset_outputs("midreset");
    @(negedge clk);
    #1;
    rst = 1'b1;
    d0 = done_cnt;
    send_frame(0, 1'b0, 0);
    wait_done(d0);
    check("t5_stream_count", acc_cnt, NPIX);
    check("t5_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    check("writes_all_seen", wexp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
